// File: rtl/uart_tx_prog.sv
// 8N1 UART transmitter with a small byte FIFO and a run-time programmable bit period.
// Line outputs are registered and trail the FSM by one cycle.
module uart_tx_prog #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] CLKS_PER_BIT,
  input  logic        i_Tx_DV,
  input  logic [7:0]  i_Tx_Byte,
  output logic        o_Tx_Ready,
  output logic        o_Tx_Serial,
  output logic        o_Tx_Active,
  output logic        o_Tx_Done,
  output logic        o_Tx_Empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   ZERO_CNT = (AW + 1)'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_e;

  state_e        state_r, state_s;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_s, pop_s;
  logic [7:0]    shift_r;
  logic [15:0]   period_r, bit_cnt_r;
  logic [2:0]    bit_idx_r;
  logic          bit_end_s;
  logic          serial_s, active_s, done_s;
  logic          serial_r, active_r, done_r;

  assign o_Tx_Ready  = (count_r != FULL_CNT);
  assign o_Tx_Empty  = (count_r == ZERO_CNT) && (state_r == IDLE);
  assign o_Tx_Serial = serial_r;
  assign o_Tx_Active = active_r;
  assign o_Tx_Done   = done_r;

  assign push_s    = i_Tx_DV && o_Tx_Ready;
  assign pop_s     = (state_r == IDLE) && (count_r != ZERO_CNT);
  assign bit_end_s = (bit_cnt_r == (period_r - 16'd1));

  // FIFO storage, wrapping pointers and occupancy count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= ZERO_CNT;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= i_Tx_Byte;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CNT_ONE;
      end else if (!push_s && pop_s) begin
        count_r <= count_r - CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Next-state logic; unused encodings fall back to IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pop_s) state_s = START;
        else       state_s = IDLE;
      end
      START: begin
        if (bit_end_s) state_s = DATA;
        else           state_s = START;
      end
      DATA: begin
        if (bit_end_s && (bit_idx_r == 3'd7)) state_s = STOP;
        else                                  state_s = DATA;
      end
      STOP: begin
        if (bit_end_s) state_s = CLEANUP;
        else           state_s = STOP;
      end
      CLEANUP: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register plus frame datapath: shifter, latched period, bit timers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= IDLE;
      shift_r   <= 8'h00;
      period_r  <= 16'd0;
      bit_cnt_r <= 16'd0;
      bit_idx_r <= 3'd0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            shift_r  <= mem_r[rd_ptr_r];
            // the period is frozen here so later CLKS_PER_BIT edits wait for the next frame
            period_r <= (CLKS_PER_BIT == 16'd0) ? 16'd1 : CLKS_PER_BIT;
          end else begin
            shift_r  <= shift_r;
          end
          bit_cnt_r <= 16'd0;
          bit_idx_r <= 3'd0;
        end
        START, STOP: begin
          bit_cnt_r <= bit_end_s ? 16'd0 : (bit_cnt_r + 16'd1);
        end
        DATA: begin
          if (bit_end_s) begin
            bit_cnt_r <= 16'd0;
            shift_r   <= {1'b0, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
          end else begin
            bit_cnt_r <= bit_cnt_r + 16'd1;
          end
        end
        default: begin
          bit_cnt_r <= 16'd0;
          bit_idx_r <= 3'd0;
        end
      endcase
    end
  end

  // Line-side decode of the current state
  always_comb begin
    serial_s = 1'b1;
    active_s = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      START: begin
        serial_s = 1'b0;
        active_s = 1'b1;
      end
      DATA: begin
        serial_s = shift_r[0];
        active_s = 1'b1;
      end
      STOP: begin
        active_s = 1'b1;
      end
      // registered one cycle later, this lands exactly as the stop bit leaves the line
      CLEANUP: begin
        done_s = 1'b1;
      end
      default: begin
        serial_s = 1'b1;
      end
    endcase
  end

  // Registered line outputs; reset forces the line idle immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      serial_r <= 1'b1;
      active_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      serial_r <= serial_s;
      active_r <= active_s;
      done_r   <= done_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_prog.sv
// Directed bench for uart_tx_prog: expected frames are queued at write time and
// checked cycle by cycle by a line monitor acting as the receiver.
module tb_uart_tx_prog;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [15:0] clks;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_ready, tx_serial, tx_active, tx_done, tx_empty;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    int         p;
    bit         b2b;
  } exp_t;

  exp_t       sbq[$];
  exp_t       cur;
  bit         in_frame = 1'b0;
  int         mon_c = 0;
  int         gap = 100;
  int         bit_i;
  logic       exp_lvl;
  logic [7:0] rx;

  uart_tx_prog #(.FIFO_DEPTH(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .CLKS_PER_BIT (clks),
    .i_Tx_DV      (tx_dv),
    .i_Tx_Byte    (tx_byte),
    .o_Tx_Ready   (tx_ready),
    .o_Tx_Serial  (tx_serial),
    .o_Tx_Active  (tx_active),
    .o_Tx_Done    (tx_done),
    .o_Tx_Empty   (tx_empty)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one write strobe; expected frames go to the scoreboard only if the byte should be taken
  task automatic write_byte(input logic [7:0] b, input int p, input bit b2b, input bit accept);
    tx_dv   = 1'b1;
    tx_byte = b;
    check("ready_at_write", 32'(tx_ready), 32'(accept));
    if (accept) sbq.push_back('{b, p, b2b});
    @(posedge clk_i); #1;
    tx_dv = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while ((sbq.size() != 0 || in_frame || gap < 3) && n < max_cycles) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("idle_within_budget", 32'(n < max_cycles), 32'd1);
    check("empty_when_idle", 32'(tx_empty), 32'd1);
  endtask

  task automatic wait_data(input int min_c, input int max_cycles);
    int n;
    n = 0;
    while (!(in_frame && mon_c >= min_c) && n < max_cycles) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("reached_data_bits", 32'(n < max_cycles), 32'd1);
  endtask

  // Line monitor: pops the scoreboard at each start bit and checks every cycle of the frame
  always @(negedge clk_i) begin
    if (rst_ni !== 1'b1) begin
      in_frame = 1'b0;
      gap      = 100;
    end else if (!in_frame) begin
      if (tx_serial === 1'b0) begin
        check("frame_expected", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          cur = sbq.pop_front();
          if (cur.b2b) check("gap_back_to_back", 32'(gap), 32'd2);
          else         check("gap_min", 32'(gap >= 2), 32'd1);
          check("active_at_start", 32'(tx_active), 32'd1);
          in_frame = 1'b1;
          mon_c    = 0;
          rx       = 8'h00;
        end
      end else begin
        if (gap < 100) gap++;
        check("done_low_idle", 32'(tx_done), 32'd0);
      end
    end else begin
      mon_c = mon_c + 1;
      if (mon_c < 10 * cur.p) begin
        bit_i = mon_c / cur.p;
        if (bit_i == 0)      exp_lvl = 1'b0;
        else if (bit_i == 9) exp_lvl = 1'b1;
        else                 exp_lvl = cur.data[bit_i-1];
        check("line_level", 32'(tx_serial), 32'(exp_lvl));
        check("active_in_frame", 32'(tx_active), 32'd1);
        check("done_low_in_frame", 32'(tx_done), 32'd0);
        if (bit_i >= 1 && bit_i <= 8 && (mon_c % cur.p) == (cur.p / 2)) rx[bit_i-1] = tx_serial;
      end else begin
        check("done_pulse_end", 32'(tx_done), 32'd1);
        check("active_low_end", 32'(tx_active), 32'd0);
        check("line_high_end", 32'(tx_serial), 32'd1);
        check("rx_byte", 32'(rx), 32'(cur.data));
        in_frame = 1'b0;
        gap      = 1;
      end
    end
  end

  initial begin
    rst_ni  = 1'b0;
    tx_dv   = 1'b0;
    tx_byte = 8'h00;
    clks    = 16'd4;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_serial", 32'(tx_serial), 32'd1);
    check("rst_active", 32'(tx_active), 32'd0);
    check("rst_done",   32'(tx_done),   32'd0);
    check("rst_ready",  32'(tx_ready),  32'd1);
    check("rst_empty",  32'(tx_empty),  32'd1);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // 0xA5 at 4 cycles per bit, with two-edge start latency
    write_byte(8'hA5, 4, 1'b0, 1'b1);
    check("empty_after_write", 32'(tx_empty), 32'd0);
    @(posedge clk_i); #1;
    check("latency_n1_high", 32'(tx_serial), 32'd1);
    @(posedge clk_i); #1;
    check("latency_n2_start", 32'(tx_serial), 32'd0);
    wait_idle(200);

    // 0 and 1 both give one cycle per bit
    clks = 16'd0;
    write_byte(8'h3C, 1, 1'b0, 1'b1);
    wait_idle(100);
    clks = 16'd1;
    write_byte(8'h3C, 1, 1'b0, 1'b1);
    wait_idle(100);

    // Fill the FIFO: five taken (one popped straight away), sixth dropped
    clks = 16'd8;
    write_byte(8'h11, 8, 1'b0, 1'b1);
    write_byte(8'h22, 8, 1'b1, 1'b1);
    write_byte(8'h33, 8, 1'b1, 1'b1);
    write_byte(8'h44, 8, 1'b1, 1'b1);
    write_byte(8'h55, 8, 1'b1, 1'b1);
    write_byte(8'h66, 8, 1'b1, 1'b0);
    check("ready_low_full", 32'(tx_ready), 32'd0);
    repeat (20) @(posedge clk_i);
    #1;
    check("ready_low_hold", 32'(tx_ready), 32'd0);
    wait_idle(1000);

    // Period change during data bit 2 only affects the next frame
    clks = 16'd8;
    write_byte(8'hC3, 8, 1'b0, 1'b1);
    write_byte(8'h5A, 3, 1'b1, 1'b1);
    wait_data(26, 200);
    clks = 16'd3;
    wait_idle(500);

    // Reset mid-data with two bytes still queued
    clks = 16'd8;
    write_byte(8'hA1, 8, 1'b0, 1'b1);
    write_byte(8'hB2, 8, 1'b1, 1'b1);
    write_byte(8'hC4, 8, 1'b1, 1'b1);
    wait_data(30, 200);
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    check("abort_serial", 32'(tx_serial), 32'd1);
    check("abort_active", 32'(tx_active), 32'd0);
    check("abort_ready",  32'(tx_ready),  32'd1);
    check("abort_empty",  32'(tx_empty),  32'd1);
    sbq.delete();
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (200) @(posedge clk_i);
    #1;
    check("post_reset_empty",  32'(tx_empty),  32'd1);
    check("post_reset_serial", 32'(tx_serial), 32'd1);

    // Long period stream at 87 cycles per bit
    clks = 16'd87;
    write_byte(8'h00, 87, 1'b0, 1'b1);
    write_byte(8'hFF, 87, 1'b1, 1'b1);
    write_byte(8'h55, 87, 1'b1, 1'b1);
    wait_idle(4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_prog.md
UART_TX_PROG -- requirements
Module: uart_tx_prog

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, transmit FIFO entry count; the only legal values are powers of two, 2..16.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 CLKS_PER_BIT  input  16  bit period in clk_i cycles = f(clk_i)/baud; 0 and 1 both mean 1 cycle per bit.
REQ-005 i_Tx_DV  input  1  write strobe; byte accepted on a rising edge where i_Tx_DV=1 and o_Tx_Ready=1.
REQ-006 i_Tx_Byte  input  8  byte to transmit, sampled with i_Tx_DV.
REQ-007 o_Tx_Ready  output  1  FIFO not full.
REQ-008 o_Tx_Serial  output  1  serial line, registered, idle high.
REQ-009 o_Tx_Active  output  1  high while a frame is on the line (START through STOP).
REQ-010 o_Tx_Done  output  1  one-cycle pulse at the end of each stop bit.
REQ-011 o_Tx_Empty  output  1  FIFO empty and state IDLE.

Function
REQ-012 The frame format SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1.
REQ-013 The FIFO SHALL be FIFO_DEPTH x 8 with wrapping read/write pointers and a count of log2(FIFO_DEPTH)+1 bits; a write while full SHALL be dropped with no state change.
REQ-014 A simultaneous write and pop SHALL leave the count unchanged and store the written byte.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP, CLEANUP, with an encoding of 3 bits.
REQ-016 The encodings 5, 6 and 7 SHALL return to IDLE on the next edge with o_Tx_Serial=1.
REQ-017 IDLE with the FIFO not empty SHALL pop the head byte into a shift register and latch P=max(CLKS_PER_BIT,1) for the whole frame, going to START on the same edge.
REQ-018 A change of CLKS_PER_BIT mid-frame SHALL have no effect on the frame in progress.
REQ-019 START, each DATA bit and STOP SHALL each hold o_Tx_Serial for exactly P cycles, using a 16-bit counter 0..P-1 that is cleared at each bit boundary.
REQ-020 DATA SHALL use a 3-bit bit index and leave for STOP after index 7 completes.
REQ-021 At the end of STOP, o_Tx_Done SHALL pulse high for 1 cycle and the FSM SHALL go to CLEANUP.
REQ-022 CLEANUP SHALL last 1 cycle with o_Tx_Serial=1 and then go to IDLE, so the line idles for at least 2 cycles between frames.
REQ-023 Latency: a byte written into an empty FIFO while in IDLE at edge N SHALL produce o_Tx_Serial=0 from edge N+2.
REQ-024 A frame SHALL occupy 10*P cycles on the line.
REQ-025 o_Tx_Ready SHALL be combinational from the count, and a pop at an edge SHALL raise it for the following cycle.

Reset
REQ-026 Reset assertion SHALL act immediately and, mid-frame, abort the frame.
REQ-027 During reset: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1, o_Tx_Empty=1, FSM=IDLE, FIFO pointers and count=0, counters=0.
REQ-028 No FIFO content SHALL survive reset.

Verification
REQ-029 CLKS_PER_BIT=4, write 0xA5 -> line shows 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles; o_Tx_Done pulses once at cycle 40 after the start bit.
REQ-030 CLKS_PER_BIT=0 and CLKS_PER_BIT=1, write 0x3C -> identical 10-cycle frames.
REQ-031 FIFO_DEPTH=4, P=8, write 6 bytes back-to-back -> 5 accepted, 6th dropped, o_Tx_Ready low while full; bytes 1..5 are sent in order with a 2-cycle high gap between frames.
REQ-032 Change CLKS_PER_BIT from 8 to 3 during data bit 2 -> the current frame stays at 8 cycles per bit; the next frame uses 3.
REQ-033 Assert rst_ni low mid-DATA with 2 bytes queued -> o_Tx_Serial=1 immediately; after release, no frame is sent and o_Tx_Empty=1.
REQ-034 Loopback into the existing receiver with CLKS_PER_BIT=87, bytes 0x00, 0xFF, 0x55 -> the receiver outputs the same bytes with one valid pulse each.
